// File: rtl/mul_sign_hilo_pkg.sv
// mul_sign_hilo_pkg: shared state encoding, width default and HI/LO half selects
package mul_sign_hilo_pkg;
  localparam int WIDTH_DEF = 32;
  localparam logic SEL_LO = 1'b0;
  localparam logic SEL_HI = 1'b1;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT   = 3'd1,
    FIX_LO = 3'd2,
    FIX_HI = 3'd3,
    WB     = 3'd4
  } state_t;
endpackage

// File: rtl/cond_negate_32.sv
// cond_negate_32: y = ~x + cin with carry-out
module cond_negate_32 #(
  parameter int W = 32
) (
  input  logic [W-1:0] x,
  input  logic         cin,
  output logic [W-1:0] y,
  output logic         cout
);
  assign {cout, y} = {1'b0, ~x} + {{W{1'b0}}, cin};
endmodule

// File: rtl/mul_sign_hilo.sv
// mul_sign_hilo: signed/unsigned wrapper around an unsigned multiplier with HI/LO result registers
module mul_sign_hilo
  import mul_sign_hilo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [WIDTH-1:0]   mag_a,
  output logic [WIDTH-1:0]   mag_b,
  input  logic               prod_valid,
  input  logic [2*WIDTH-1:0] prod,
  input  logic               mthi,
  input  logic               mtlo,
  input  logic [WIDTH-1:0]   wdata,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic               busy,
  output logic               done
);
  state_t state, state_nx;
  logic neg, carry, sa, sb, fcin, fc, wr_ok, unused_ca, unused_cb;
  logic [1:0][WIDTH-1:0] tmp;
  logic [WIDTH-1:0] na, nb, fx, fy;
  assign sa = is_signed & A[WIDTH-1];
  assign sb = is_signed & B[WIDTH-1];
  assign wr_ok = !busy && state != WB;
  // one negator serves both fix-up passes: LO adds 1, HI adds the LO carry
  assign fx = state == FIX_HI ? tmp[SEL_HI] : tmp[SEL_LO];
  assign fcin = state == FIX_HI ? carry : 1'b1;
  cond_negate_32 #(.W(WIDTH)) u_neg_a (.x(A), .cin(1'b1), .y(na), .cout(unused_ca));
  cond_negate_32 #(.W(WIDTH)) u_neg_b (.x(B), .cin(1'b1), .y(nb), .cout(unused_cb));
  cond_negate_32 #(.W(WIDTH)) u_fix (.x(fx), .cin(fcin), .y(fy), .cout(fc));
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = start ? WAIT : IDLE;
      WAIT:    state_nx = prod_valid ? (neg ? FIX_LO : WB) : WAIT;
      FIX_LO:  state_nx = FIX_HI;
      FIX_HI:  state_nx = WB;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi    <= '0;
      lo    <= '0;
      mag_a <= '0;
      mag_b <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      neg   <= 1'b0;
      carry <= 1'b0;
      tmp   <= '0;
    end else begin
      done <= state == WB;
      if (state == IDLE && start) begin
        mag_a <= sa ? na : A;
        mag_b <= sb ? nb : B;
        neg   <= is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
        busy  <= 1'b1;
      end
      if (state == WAIT && prod_valid) tmp <= prod;
      if (state == FIX_LO) begin
        tmp[SEL_LO] <= fy;
        carry       <= fc;
      end
      if (state == FIX_HI) tmp[SEL_HI] <= fy;
      if (state == WB) begin
        hi   <= tmp[SEL_HI];
        lo   <= tmp[SEL_LO];
        busy <= 1'b0;
      end else begin
        if (wr_ok && mthi) hi <= wdata;
        if (wr_ok && mtlo) lo <= wdata;
      end
    end
  end
endmodule

// File: tb/tb_mul_sign_hilo.sv
// tb_mul_sign_hilo: random and directed checks of mul_sign_hilo against an arithmetic model
module tb_mul_sign_hilo;
  logic clk = 0, rst = 1, start = 0, is_signed = 0, prod_valid = 0, mthi = 0, mtlo = 0;
  logic [31:0] A = 0, B = 0, wdata = 0, mag_a, mag_b, hi, lo;
  logic [63:0] prod = 0;
  logic busy, done;
  int n_cmp = 0, n_bad = 0;

  mul_sign_hilo dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed), .A(A), .B(B),
    .mag_a(mag_a), .mag_b(mag_b), .prod_valid(prod_valid), .prod(prod),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sg,
                        input int dly, input logic wh, input logic [31:0] w);
    logic [63:0] ea, eb, exp, t;
    logic [31:0] ma, mb, hold;
    int lat, n;
    ea = sg ? {{32{a[31]}}, a} : {32'b0, a};
    eb = sg ? {{32{b[31]}}, b} : {32'b0, b};
    exp = ea * eb;
    t = -ea;
    ma = ea[63] ? t[31:0] : a;
    t = -eb;
    mb = eb[63] ? t[31:0] : b;
    lat = (sg && (a[31] ^ b[31])) ? 4 : 2;
    @(negedge clk);
    start = 1; is_signed = sg; A = a; B = b; mthi = wh; wdata = w;
    @(negedge clk);
    start = 0; mthi = 0; A = $urandom; B = $urandom;
    chk("busy_start", 64'(busy), 64'd1);
    chk("mag_a", 64'(mag_a), 64'(ma));
    chk("mag_b", 64'(mag_b), 64'(mb));
    if (wh) chk("start_mthi", 64'(hi), 64'(w));
    hold = hi;
    for (int i = 0; i < dly; i++) begin
      start = 1; mthi = 1; mtlo = 1; wdata = $urandom;
      @(negedge clk);
      start = 0; mthi = 0; mtlo = 0;
      chk("hi_hold_busy", 64'(hi), 64'(hold));
      chk("mag_a_hold", 64'(mag_a), 64'(ma));
    end
    prod_valid = 1; prod = {32'b0, ma} * {32'b0, mb};
    @(negedge clk);
    prod_valid = 0; prod = 64'hFF;
    n = 1;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 64'(n), 64'(lat));
    chk("hi", 64'(hi), {32'b0, exp[63:32]});
    chk("lo", 64'(lo), {32'b0, exp[31:0]});
    @(negedge clk);
    chk("done_pulse", 64'(done), 64'd0);
    chk("busy_end", 64'(busy), 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [31:0] edge_v [6];
    edge_v = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h80000001};
    #12;
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_mag_a", 64'(mag_a), 64'd0);
    chk("rst_mag_b", 64'(mag_b), 64'd0);
    @(negedge clk);
    rst = 0;
    run_op(32'd3, 32'd5, 0, 1, 0, 0);
    run_op(32'hFFFFFFFD, 32'd5, 1, 0, 0, 0);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1, 2, 0, 0);
    run_op(32'h80000000, 32'd2, 1, 0, 0, 0);
    run_op(32'd7, 32'd9, 0, 2, 1, 32'h5555);
    @(negedge clk);
    mtlo = 1; wdata = 32'hABCD;
    @(negedge clk);
    mtlo = 0;
    chk("mtlo_idle", 64'(lo), 64'hABCD);
    mthi = 1; mtlo = 1; wdata = 32'h1357;
    @(negedge clk);
    mthi = 0; mtlo = 0;
    chk("both_hi", 64'(hi), 64'h1357);
    chk("both_lo", 64'(lo), 64'h1357);
    start = 1; is_signed = 0; A = 5; B = 6;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    rst = 1;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst = 0; prod_valid = 1; prod = 64'hFF;
    @(negedge clk);
    prod_valid = 0;
    for (int i = 0; i < 5; i++) begin
      chk("abort_no_done", 64'(done), 64'd0);
      @(negedge clk);
    end
    chk("abort_hi_after", 64'(hi), 64'd0);
    chk("abort_lo_after", 64'(lo), 64'd0);
    for (int i = 0; i < 40; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 5)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 5)] : $urandom;
      run_op(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
             1'($urandom_range(0, 1)), $urandom);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
